// File: rtl/ldxa_pkg.sv
// Shared constants and helpers for the ldxa latched alarm controller.
// The state encoding is visible on the `state` debug output, so it is fixed here.
package ldxa_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ALARM     = 2'd1;
  localparam logic [1:0] ST_CLEARABLE = 2'd2;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int ctr_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ldxa_alarm_if.sv
// Sensor-side inputs and indicator-side outputs of the alarm controller.
// There is no handshake: every input is level-sampled on each rising clock edge.
interface ldxa_alarm_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] d;
  logic            x;
  logic            a;
  logic            clr;
  logic [N_CH-1:0] l;
  logic            lamp;
  logic [1:0]      state;

  modport master (
    output d, x, a, clr,
    input  l, lamp, state
  );

  modport slave (
    input  d, x, a, clr,
    output l, lamp, state
  );
endinterface

// File: rtl/ldxa_debounce.sv
// Per-channel door debouncer: d_out rises after DEB_CYC consecutive high samples.
// Any low sample restarts the count.
module ldxa_debounce
  import ldxa_pkg::*;
#(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic d_out
);

  localparam int             W       = ctr_w(DEB_CYC);
  localparam logic [W-1:0]   CNT_MAX = W'(DEB_CYC);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!d_in) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + W'(1);
    end
  end

  assign d_out = (cnt == CNT_MAX);

endmodule

// File: rtl/ldxa_alarm.sv
// Multi-channel latched alarm: debounced doors masked by disarm, plus panic,
// latch per-channel alarms that need a hold period and an acknowledge to clear.
module ldxa_alarm
  import ldxa_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DEB_CYC   = 4,
  parameter int HOLD_CYC  = 16,
  parameter int BLINK_DIV = 8
) (
  input logic         clk,
  input logic         rst,
  ldxa_alarm_if.slave bus
);

  localparam int                  HOLD_W     = ctr_w(HOLD_CYC);
  localparam int                  BLINK_W    = ctr_w(BLINK_DIV);
  localparam logic [HOLD_W-1:0]   HOLD_LOAD  = HOLD_W'(HOLD_CYC);
  localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [N_CH-1:0]    deb;
  logic [N_CH-1:0]    trig;
  logic               any_trig;
  logic [N_CH-1:0]    l_q;
  logic [1:0]         state_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [BLINK_W-1:0] blink_q;
  logic               lamp_q;
  logic               go_idle;
  logic               active;

  for (genvar i = 0; i < N_CH; i++) begin : g_deb
    ldxa_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .d_in  (bus.d[i]),
      .d_out (deb[i])
    );
  end

  // Disarm masks only door triggers; panic always fires every channel.
  assign trig     = (deb & {N_CH{~bus.x}}) | {N_CH{bus.a}};
  assign any_trig = |trig;
  assign go_idle  = (state_q == ST_CLEARABLE) && !any_trig && bus.clr;
  assign active   = (state_q == ST_ALARM) || (state_q == ST_CLEARABLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      l_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_trig) begin
            state_q <= ST_ALARM;
            hold_q  <= HOLD_LOAD;
            l_q     <= trig;
          end else begin
            l_q <= '0;
          end
        end
        ST_ALARM: begin
          l_q <= l_q | trig;
          if (any_trig) begin
            hold_q <= HOLD_LOAD;
          end else if (hold_q <= HOLD_W'(1)) begin
            hold_q  <= '0;
            state_q <= ST_CLEARABLE;
          end else begin
            hold_q <= hold_q - HOLD_W'(1);
          end
        end
        ST_CLEARABLE: begin
          if (any_trig) begin
            state_q <= ST_ALARM;
            hold_q  <= HOLD_LOAD;
            l_q     <= l_q | trig;
          end else if (bus.clr) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            l_q     <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          hold_q  <= '0;
          l_q     <= '0;
        end
      endcase
    end
  end

  // Blink phase restarts only on entry from IDLE; ALARM<->CLEARABLE keeps it running.
  always_ff @(posedge clk) begin
    if (rst) begin
      lamp_q  <= 1'b0;
      blink_q <= '0;
    end else if (state_q == ST_IDLE) begin
      lamp_q  <= any_trig;
      blink_q <= '0;
    end else if (!active || go_idle) begin
      lamp_q  <= 1'b0;
      blink_q <= '0;
    end else if (blink_q == BLINK_LAST) begin
      lamp_q  <= ~lamp_q;
      blink_q <= '0;
    end else begin
      blink_q <= blink_q + BLINK_W'(1);
    end
  end

  assign bus.l     = l_q;
  assign bus.lamp  = lamp_q;
  assign bus.state = state_q;

endmodule

// File: doc/ldxa_alarm.md
# ldxa_alarm

Multi-channel latched alarm controller generalising L = D·~X + A. Each of N_CH door sensors is debounced and combined with a global disarm key (x) and a global panic input (a). Any resulting trigger latches a per-channel alarm that is held for a minimum time. The latched alarms are cleared only by an explicit acknowledge, and a blinking summary lamp is driven while any alarm is active. The block sits between raw sensor inputs and the indicator/siren outputs of the alarm exercise.

## Interface
- N_CH, default 4: number of door channels (≥1).
- DEB_CYC, default 4: consecutive high samples required to accept a door-open (≥1).
- HOLD_CYC, default 16: minimum cycles an alarm stays uncleared after the last trigger (≥1).
- BLINK_DIV, default 8: lamp half-period in cycles (≥1).

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- d  in  N_CH  raw door-open sensors, 1 = open.
- x  in  1  disarm key, 1 = disarmed; masks door triggers only.
- a  in  1  panic; triggers all channels regardless of x.
- clr  in  1  acknowledge/clear request, level-sampled.
- l  out  N_CH  latched per-channel alarm.
- lamp  out  1  blinking summary indicator.
- state  out  2  FSM state: 0 = IDLE, 1 = ALARM, 2 = CLEARABLE.

## Operation
- Debounce, per channel:
  - Counter increments while d[i] = 1 and saturates at DEB_CYC.
  - Any d[i] = 0 sample zeroes the counter and drops deb[i].
  - deb[i] = 1 when the counter equals DEB_CYC.
- Trigger: trig[i] = (deb[i] & ~x) | a, computed combinationally from registered deb and the current x and a.
- Latch: l[i] sets on the edge where trig[i] = 1. Bits are never cleared individually; only the clear below releases them.
- FSM:
  - IDLE: l = 0. If any trig → ALARM, loading hold = HOLD_CYC.
  - ALARM: each cycle, if any trig, reload hold = HOLD_CYC. Otherwise decrement hold; when hold reaches 0 → CLEARABLE. clr is ignored in ALARM.
  - CLEARABLE: any trig → ALARM with hold = HOLD_CYC and l |= trig. Else if clr = 1 → l = 0 and go to IDLE. Else stay.
- Priority: rst > trig > clr.
- Lamp:
  - 0 in IDLE.
  - On entry to ALARM from IDLE, lamp = 1 and the blink counter is zeroed.
  - lamp toggles every BLINK_DIV cycles while in ALARM or CLEARABLE.
  - The blink phase is not reset on ALARM↔CLEARABLE transitions.
- Widths: the hold counter is $clog2(HOLD_CYC+1) bits; the debounce and blink counters are sized the same way from their parameters. No counter wraps: all saturate or reload.

## Timing
- Reset: all counters = 0, deb = 0, l = 0, lamp = 0, state = IDLE, applied on the first edge with rst = 1. Reset during ALARM or CLEARABLE aborts immediately; no residual latch.
- Door latency: d[i] rises before edge t and stays high, with x = 0.
  - deb[i] = 1 after edge t+DEB_CYC−1.
  - l[i] = 1 after edge t+DEB_CYC.
- Panic latency: a = 1 before edge t → all l bits = 1 and state = ALARM after edge t.
- Hold duration: with trig = 0 from the cycle after entry, state is ALARM for exactly HOLD_CYC cycles and then CLEARABLE.
- Clear latency: clr = 1 before edge t in CLEARABLE with no trig → l = 0, lamp = 0, state = IDLE after edge t.
- A 1-cycle d glitch shorter than DEB_CYC produces no trigger when DEB_CYC > 1.
- x rising while a door is open stops that channel's triggers but does not clear its latch.

## Structure
- Package ldxa_pkg holds:
  - state encoding constants ST_IDLE = 2'd0, ST_ALARM = 2'd1, ST_CLEARABLE = 2'd2;
  - a counter-width helper function.
- Sub-module ldxa_debounce (parameter DEB_CYC; ports clk, rst, d_in, d_out) is instantiated N_CH times via generate.
- Top-level holds trigger logic, the l register, FSM, hold counter and blink counter.

## Test plan
Parameters: N_CH = 4, DEB_CYC = 4, HOLD_CYC = 16, BLINK_DIV = 8.
- Debounce: d = 4'b0001 for 3 cycles then 0, x = 0 → l stays 4'b0000 and state stays 0. Holding d = 4'b0001 for 4+ cycles → l = 4'b0001 exactly 4 edges after the rise.
- Disarm: x = 1, d = 4'b1111 held 10 cycles → l = 0. Then a = 1 for 1 cycle → l = 4'b1111 one edge later, state = 1.
- Hold/clear: single panic pulse, clr held high throughout → state = 1 for 16 cycles, then 2; clr then clears → l = 0, state = 0 on the next edge.
- Retrigger: in CLEARABLE, assert d[2] (debounced) together with clr → state = 1, l[2] = 1, earlier bits kept, hold reloaded to 16, clr ignored.
- Lamp: after a panic entry, lamp = 1 for 8 cycles, 0 for 8, 1 for 8, …. lamp = 0 on the edge that returns to IDLE.
- Reset: rst = 1 mid-ALARM with l = 4'b1011 → next edge l = 0, lamp = 0, state = 0. A d still held high needs a full 4-cycle debounce to re-trigger after rst drops.
